// File: rtl/switch_pkg.sv
// Shared switch types: packet layout, port count and egress serializer states.
package switch_pkg;

   localparam int unsigned NUM_PORTS = 4;

   typedef struct packed {
      logic [3:0] source;
      logic [3:0] target;
      logic [7:0] data;
   } pkt_t;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      DATA
   } ser_state_e;

endpackage

// File: rtl/switch_egress_serializer_if.sv
// Ingress packet bus from the switch plus the egress byte stream toward the link.
interface switch_egress_serializer_if;

   logic       pkt_valid;
   logic [3:0] pkt_source;
   logic [3:0] pkt_target;
   logic [7:0] pkt_data;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_ready;

   // Serializer side: consumes packets, drives the byte stream.
   modport master (
      input  pkt_valid, pkt_source, pkt_target, pkt_data, tx_ready,
      output tx_valid, tx_data, tx_last
   );

   // Environment side: switch port and link sink.
   modport slave (
      output pkt_valid, pkt_source, pkt_target, pkt_data, tx_ready,
      input  tx_valid, tx_data, tx_last
   );

endinterface

// File: rtl/switch_egress_serializer_pkt_fifo.sv
// Small packet FIFO; a write when full is honoured only alongside a pop.
module pkt_fifo
   import switch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = pkt_t
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  T                       wdata_i,
   input  logic                   pop_i,
   output T                       rdata_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int unsigned     AW       = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);

   // Storage write; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   // Pointers wrap naturally at the power-of-two depth; push+pop keeps the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (!do_push && do_pop) count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/switch_egress_serializer.sv
// Per-port egress: classifies switch packets, buffers them and emits two-beat frames.
module switch_egress_serializer
   import switch_pkg::*;
#(
   parameter int unsigned PORT_ID = 0,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   switch_egress_serializer_if.master  bus,
   input  logic                        clr_cnt,
   output logic [$clog2(DEPTH):0]      fifo_count,
   output logic [CNT_W-1:0]            drop_cnt,
   output logic [CNT_W-1:0]            misroute_cnt
);

   localparam int unsigned        PW       = $clog2(NUM_PORTS);
   localparam logic [PW-1:0]      PORT_SEL = PW'(PORT_ID);

   ser_state_e       state_q, state_d;
   logic             tx_valid_q, tx_valid_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_last_q, tx_last_d;
   logic [7:0]       cur_data_q, cur_data_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

   pkt_t fifo_wdata;
   pkt_t fifo_head;
   logic fifo_full, fifo_empty;
   logic pop, push, hs, routed, drop_inc, mis_inc;

   assign fifo_wdata = '{source: bus.pkt_source, target: bus.pkt_target, data: bus.pkt_data};
   assign hs         = tx_valid_q && bus.tx_ready;
   assign routed     = bus.pkt_target[PORT_SEL];
   assign mis_inc    = bus.pkt_valid && !routed;
   assign push       = bus.pkt_valid && routed && (!fifo_full || pop);
   assign drop_inc   = bus.pkt_valid && routed && fifo_full && !pop;

   pkt_fifo #(
      .DEPTH (DEPTH),
      .T     (pkt_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i (fifo_wdata),
      .pop_i   (pop),
      .rdata_o (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Frame sequencing: pop on beat0 load, chain frames back-to-back from DATA.
   always_comb begin
      state_d    = state_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      tx_last_d  = tx_last_q;
      cur_data_d = cur_data_q;
      pop        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_d    = HDR;
               tx_valid_d = 1'b1;
               tx_data_d  = {fifo_head.source, fifo_head.target};
               tx_last_d  = 1'b0;
               cur_data_d = fifo_head.data;
            end
         end
         HDR: begin
            if (hs) begin
               state_d   = DATA;
               tx_data_d = cur_data_q;
               tx_last_d = 1'b1;
            end
         end
         DATA: begin
            if (hs) begin
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  state_d    = HDR;
                  tx_data_d  = {fifo_head.source, fifo_head.target};
                  tx_last_d  = 1'b0;
                  cur_data_d = fifo_head.data;
               end else begin
                  state_d    = IDLE;
                  tx_valid_d = 1'b0;
                  tx_last_d  = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Saturating event counters; a clear wins over a same-cycle increment.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      mis_cnt_d  = mis_cnt_q;
      if (clr_cnt) begin
         drop_cnt_d = '0;
         mis_cnt_d  = '0;
      end else begin
         if (drop_inc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
         if (mis_inc && (mis_cnt_q != '1))   mis_cnt_d  = mis_cnt_q + 1'b1;
      end
   end

   // State, registered tx outputs and counters; reset abandons any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         tx_last_q  <= 1'b0;
         cur_data_q <= '0;
         drop_cnt_q <= '0;
         mis_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         tx_last_q  <= tx_last_d;
         cur_data_q <= cur_data_d;
         drop_cnt_q <= drop_cnt_d;
         mis_cnt_q  <= mis_cnt_d;
      end
   end

   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_last  = tx_last_q;
   assign drop_cnt     = drop_cnt_q;
   assign misroute_cnt = mis_cnt_q;

endmodule
